// File: rtl/cell_render_pkg.sv
// Shared command/state types and width helpers for the cell render engine.
package cell_render_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_OUTLINE = 3'd1,
    CMD_CLEAN   = 3'd2,
    CMD_FILL    = 3'd3,
    CMD_ERASE   = 3'd4,
    CMD_CLEAR   = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int max_dim(input int w, input int h);
    return (w > h) ? w : h;
  endfunction

  function automatic int pix_w(input int w, input int h);
    return $clog2(max_dim(w, h)) + 1;
  endfunction

  function automatic int cell_w(input int w, input int h, input int d);
    return $clog2(max_dim(w, h) / d);
  endfunction

endpackage

// File: rtl/cell_render_engine_raster.sv
// 2-D raster counter: loads a rectangle (start/last corners), steps row-major on en.
module raster_counter #(
  parameter int W = 10
) (
  input  logic         iClk,
  input  logic         iResetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] x_start,
  input  logic [W-1:0] x_last,
  input  logic [W-1:0] y_start,
  input  logic [W-1:0] y_last,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         x_first,
  output logic         x_end,
  output logic         y_first,
  output logic         y_end,
  output logic         last
);
  logic [W-1:0] x_lo, x_hi, y_lo, y_hi;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      x    <= '0;
      y    <= '0;
      x_lo <= '0;
      x_hi <= '0;
      y_lo <= '0;
      y_hi <= '0;
    end else if (load) begin
      x    <= x_start;
      y    <= y_start;
      x_lo <= x_start;
      x_hi <= x_last;
      y_lo <= y_start;
      y_hi <= y_last;
    end else if (en) begin
      if (x_end) begin
        x <= x_lo;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign x_first = (x == x_lo);
  assign x_end   = (x == x_hi);
  assign y_first = (y == y_lo);
  assign y_end   = (y == y_hi);
  assign last    = x_end & y_end;

endmodule

// File: rtl/cell_render_engine.sv
// Cell-grid pixel stream generator; optional back-pressure via CELL_RENDER_STALL_EN.
// state   | meaning
// IDLE    | ready for a command
// SCAN    | emitting one registered pixel per step; fin_q marks last pixel emitted
// DONE    | oDone pulse, back to IDLE next cycle
module cell_render_engine
  import cell_render_pkg::*;
#(
  parameter int                  SCREEN_WIDTH  = 640,
  parameter int                  SCREEN_HEIGHT = 480,
  parameter int                  CELL_DIM      = 5,
  parameter int                  COLOUR_W      = 3,
  parameter logic [COLOUR_W-1:0] CURSOR_COLOUR = 3'b110,
  parameter logic [COLOUR_W-1:0] GRID_COLOUR   = 3'b000,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b111,
  localparam int PIX_W  = pix_w(SCREEN_WIDTH, SCREEN_HEIGHT),
  localparam int CELL_W = cell_w(SCREEN_WIDTH, SCREEN_HEIGHT, CELL_DIM)
) (
  input  logic                iClk,
  input  logic                iResetn,
  input  logic                iCmdValid,
  output logic                oCmdReady,
  input  logic [2:0]          iCmd,
  input  logic [CELL_W-1:0]   iX_cell,
  input  logic [CELL_W-1:0]   iY_cell,
  input  logic [COLOUR_W-1:0] iColour,
`ifdef CELL_RENDER_STALL_EN
  input  logic                iPixelReady,
`endif
  output logic [PIX_W-1:0]    oX_pixel,
  output logic [PIX_W-1:0]    oY_pixel,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oDone
);
  localparam int               PH_W   = $clog2(CELL_DIM);
  localparam int               COLS   = SCREEN_WIDTH / CELL_DIM;
  localparam int               ROWS   = SCREEN_HEIGHT / CELL_DIM;
  localparam logic [PIX_W-1:0] DIM    = PIX_W'(CELL_DIM);
  localparam logic [PIX_W-1:0] DIM_M1 = PIX_W'(CELL_DIM - 1);
  localparam logic [PIX_W-1:0] DIM_M2 = PIX_W'(CELL_DIM - 2);
  localparam logic [PIX_W-1:0] ONE    = PIX_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CELL_DIM - 1);

  state_e                state_q, state_d;
  logic                  adv, ld, step, fin_q, in_range, no_pix;
  logic                  outline_q, clear_q, grid;
  logic [COLOUR_W-1:0]   colour_q, colour_in;
  logic [PIX_W-1:0]      base_x, base_y, xs, xl, ys, yl, cnt_x, cnt_y;
  logic                  x_first, x_end, y_first, y_end, cnt_last;
  logic [PH_W-1:0]       ph_x, ph_y;

`ifdef CELL_RENDER_STALL_EN
  assign adv = iPixelReady;
`else
  assign adv = 1'b1;
`endif

  assign oCmdReady = (state_q == ST_IDLE);
  assign oDone     = (state_q == ST_DONE);

  // Rectangle and colour for the incoming command, evaluated only at accept.
  always_comb begin
    base_x    = PIX_W'(iX_cell) * DIM;
    base_y    = PIX_W'(iY_cell) * DIM;
    in_range  = (32'(iX_cell) < COLS) && (32'(iY_cell) < ROWS);
    xs        = base_x;
    ys        = base_y;
    xl        = base_x + DIM_M1;
    yl        = base_y + DIM_M1;
    no_pix    = 1'b0;
    colour_in = GRID_COLOUR;
    case (iCmd)
      CMD_OUTLINE, CMD_CLEAN: begin
        no_pix    = !in_range;
        colour_in = (iCmd == CMD_OUTLINE) ? CURSOR_COLOUR : GRID_COLOUR;
      end
      CMD_FILL, CMD_ERASE: begin
        xs        = base_x + ONE;
        ys        = base_y + ONE;
        xl        = base_x + DIM_M2;
        yl        = base_y + DIM_M2;
        no_pix    = !in_range;
        colour_in = (iCmd == CMD_FILL) ? iColour : BG_COLOUR;
      end
      CMD_CLEAR: begin
        xs = '0;
        ys = '0;
        xl = PIX_W'(SCREEN_WIDTH - 1);
        yl = PIX_W'(SCREEN_HEIGHT - 1);
      end
      default: no_pix = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: if (iCmdValid) begin
        ld      = 1'b1;
        state_d = ST_SCAN;
      end
      ST_SCAN: if (adv) begin
        if (fin_q) state_d = ST_DONE;
        else       step    = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  raster_counter #(.W(PIX_W)) u_raster (
    .iClk    (iClk),
    .iResetn (iResetn),
    .load    (ld),
    .en      (step),
    .x_start (xs),
    .x_last  (xl),
    .y_start (ys),
    .y_last  (yl),
    .x       (cnt_x),
    .y       (cnt_y),
    .x_first (x_first),
    .x_end   (x_end),
    .y_first (y_first),
    .y_end   (y_end),
    .last    (cnt_last)
  );

  assign grid = (ph_x == '0) || (ph_x == PH_LAST) || (ph_y == '0) || (ph_y == PH_LAST);

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      fin_q     <= 1'b0;
      outline_q <= 1'b0;
      clear_q   <= 1'b0;
      colour_q  <= BG_COLOUR;
      ph_x      <= '0;
      ph_y      <= '0;
      oX_pixel  <= '0;
      oY_pixel  <= '0;
      oColour   <= BG_COLOUR;
      oPlot     <= 1'b0;
    end else if (ld) begin
      fin_q     <= no_pix;
      outline_q <= (iCmd == CMD_OUTLINE) || (iCmd == CMD_CLEAN);
      clear_q   <= (iCmd == CMD_CLEAR);
      colour_q  <= colour_in;
      ph_x      <= '0;
      ph_y      <= '0;
    end else if (step) begin
      fin_q    <= cnt_last;
      oX_pixel <= cnt_x;
      oY_pixel <= cnt_y;
      oPlot    <= outline_q ? (x_first | x_end | y_first | y_end) : 1'b1;
      oColour  <= !clear_q ? colour_q : (grid ? GRID_COLOUR : BG_COLOUR);
      // Phase counters stand in for x/y mod CELL_DIM during CLEAR.
      if (x_end) begin
        ph_x <= '0;
        ph_y <= (ph_y == PH_LAST) ? '0 : ph_y + 1'b1;
      end else begin
        ph_x <= (ph_x == PH_LAST) ? '0 : ph_x + 1'b1;
      end
    end else if (adv) begin
      oPlot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cell_render_engine.sv
// Self-checking bench for cell_render_engine on a reduced 60x45 screen.
module tb_cell_render_engine;
  import cell_render_pkg::*;

  localparam int W = 60;
  localparam int H = 45;
  localparam int D = 5;
  localparam int PIX_W  = pix_w(W, H);
  localparam int CELL_W = cell_w(W, H, D);

  logic              iClk = 1'b0, iResetn = 1'b0, iCmdValid = 1'b0, pixel_ready = 1'b1;
  logic              oCmdReady, oPlot, oDone;
  logic [2:0]        iCmd = 3'd0, iColour = 3'd0, oColour;
  logic [CELL_W-1:0] iX_cell = '0, iY_cell = '0;
  logic [PIX_W-1:0]  oX_pixel, oY_pixel;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic [2:0]       c;
  } pix_t;
  pix_t exp_q[$];

  typedef struct {
    logic [2:0] cmd;
    int         cx;
    int         cy;
    logic [2:0] col;
    int         plots;
    int         done_at;
    string      nm;
  } vec_t;
  vec_t vecs[10];

  always #5 iClk = ~iClk;

  cell_render_engine #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .CELL_DIM     (D)
  ) dut (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iCmdValid (iCmdValid),
    .oCmdReady (oCmdReady),
    .iCmd      (iCmd),
    .iX_cell   (iX_cell),
    .iY_cell   (iY_cell),
    .iColour   (iColour),
`ifdef CELL_RENDER_STALL_EN
    .iPixelReady(pixel_ready),
`endif
    .oX_pixel  (oX_pixel),
    .oY_pixel  (oY_pixel),
    .oColour   (oColour),
    .oPlot     (oPlot),
    .oDone     (oDone)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_pix(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = PIX_W'(x);
    p.y = PIX_W'(y);
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Reference raster computed directly from geometry.
  task automatic push_model(input logic [2:0] cmd, input int cx, input int cy, input logic [2:0] col);
    bit cell_cmd, edge_px;
    cell_cmd = (cmd >= 3'd1) && (cmd <= 3'd4);
    if (cmd == 3'd5) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          edge_px = (x % D == 0) || (x % D == D - 1) || (y % D == 0) || (y % D == D - 1);
          push_pix(x, y, edge_px ? 3'b000 : 3'b111);
        end
    end else if (cell_cmd && cx < W / D && cy < H / D) begin
      if (cmd <= 3'd2) begin
        for (int ly = 0; ly < D; ly++)
          for (int lx = 0; lx < D; lx++)
            if (lx == 0 || lx == D - 1 || ly == 0 || ly == D - 1)
              push_pix(cx * D + lx, cy * D + ly, (cmd == 3'd1) ? 3'b110 : 3'b000);
      end else begin
        for (int ly = 1; ly < D - 1; ly++)
          for (int lx = 1; lx < D - 1; lx++)
            push_pix(cx * D + lx, cy * D + ly, (cmd == 3'd3) ? col : 3'b111);
      end
    end
  endtask

  task automatic run(input logic [2:0] c, input int cx, input int cy, input logic [2:0] col,
                     input int exp_plots, input int exp_done, input bit toggle, input string nm);
    int   plots, done_k, budget;
    pix_t e, held;
    bit   held_v;
    push_model(c, cx, cy, col);
    plots  = 0;
    done_k = -1;
    held_v = 1'b0;
    budget = (exp_done < 0) ? 400 : exp_done + 20;
    @(negedge iClk);
    chk({nm, " ready before"}, 32'(oCmdReady), 32'd1);
    iCmdValid = 1'b1;
    iCmd      = c;
    iX_cell   = CELL_W'(cx);
    iY_cell   = CELL_W'(cy);
    iColour   = col;
    @(posedge iClk);
    #1;
    iCmdValid = 1'b0;
    iCmd      = 3'($urandom);
    iX_cell   = CELL_W'($urandom);
    iY_cell   = CELL_W'($urandom);
    iColour   = ~col;
    for (int k = 0; k <= budget && done_k < 0; k++) begin
      @(negedge iClk);
      if (k == 0) chk({nm, " busy after accept"}, 32'(oCmdReady), 32'd0);
      if (held_v) begin
        chk({nm, " held pixel"}, 32'({oPlot, oX_pixel, oY_pixel, oColour}), 32'({1'b1, held}));
        held_v = 1'b0;
      end
      if (oPlot) begin
        if (pixel_ready) begin
          plots++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected pixel: got x=%0d y=%0d c=%0h", nm, oX_pixel, oY_pixel, oColour);
          end else begin
            e = exp_q.pop_front();
            chk({nm, " pixel"}, 32'({oX_pixel, oY_pixel, oColour}), 32'(e));
          end
        end else begin
          held   = {oX_pixel, oY_pixel, oColour};
          held_v = 1'b1;
        end
      end
      if (oDone) begin
        done_k = k;
        chk({nm, " plot low at done"}, 32'(oPlot), 32'd0);
      end
      if (toggle) pixel_ready = 1'($urandom_range(0, 1));
    end
    pixel_ready = 1'b1;
    if (done_k < 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, budget);
    end else begin
      if (exp_done >= 0) chk({nm, " done cycle"}, 32'(done_k), 32'(exp_done));
      @(negedge iClk);
      chk({nm, " ready after done"}, 32'(oCmdReady), 32'd1);
      chk({nm, " single done"}, 32'(oDone), 32'd0);
    end
    chk({nm, " plot count"}, 32'(plots), 32'(exp_plots));
    chk({nm, " queue drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int plots;
    bit saw_done;
    vecs[0] = '{3'd1, 2, 3, 3'b000, 16, 26, "outline"};
    vecs[1] = '{3'd3, 2, 3, 3'b010, 9, 10, "fill"};
    vecs[2] = '{3'd2, 0, 0, 3'b000, 16, 26, "clean"};
    vecs[3] = '{3'd4, 11, 8, 3'b010, 9, 10, "erase"};
    vecs[4] = '{3'd1, 12, 0, 3'b000, 0, 1, "outline oor x"};
    vecs[5] = '{3'd3, 0, 9, 3'b101, 0, 1, "fill oor y"};
    vecs[6] = '{3'd0, 1, 1, 3'b000, 0, 1, "nop"};
    vecs[7] = '{3'd7, 7, 7, 3'b000, 0, 1, "cmd7"};
    vecs[8] = '{3'd5, 0, 0, 3'b000, W * H, W * H + 1, "clear"};
    vecs[9] = '{3'd3, 11, 0, 3'b101, 9, 10, "fill edge"};

    #12;
    chk("reset ready", 32'(oCmdReady), 32'd1);
    chk("reset plot", 32'(oPlot), 32'd0);
    chk("reset done", 32'(oDone), 32'd0);
    chk("reset colour", 32'(oColour), 32'h7);
    chk("reset xy", 32'({oX_pixel, oY_pixel}), 32'd0);
    @(negedge iClk);
    iResetn = 1'b1;

    foreach (vecs[i])
      run(vecs[i].cmd, vecs[i].cx, vecs[i].cy, vecs[i].col, vecs[i].plots, vecs[i].done_at, 1'b0, vecs[i].nm);

    // Abort a CLEAR part-way with reset.
    @(negedge iClk);
    iCmdValid = 1'b1;
    iCmd      = 3'd5;
    @(posedge iClk);
    #1;
    iCmdValid = 1'b0;
    plots = 0;
    for (int k = 0; k < 2000 && plots < 1000; k++) begin
      @(negedge iClk);
      if (oPlot) plots++;
    end
    chk("clear reached pixel 1000", 32'(plots), 32'd1000);
    #2 iResetn = 1'b0;
    #1;
    chk("abort plot", 32'(oPlot), 32'd0);
    chk("abort xy", 32'({oX_pixel, oY_pixel}), 32'd0);
    chk("abort colour", 32'(oColour), 32'h7);
    chk("abort ready", 32'(oCmdReady), 32'd1);
    repeat (2) @(negedge iClk);
    iResetn  = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge iClk);
      if (oDone || oPlot) saw_done = 1'b1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    run(3'd1, 2, 3, 3'b000, 16, 26, 1'b0, "outline after abort");

`ifdef CELL_RENDER_STALL_EN
    run(3'd3, 2, 3, 3'b010, 9, -1, 1'b1, "stall fill");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
